// File: rtl/proc_pkg.sv
// Shared types and constants for the multicycle sequencer and its benches.
package proc_pkg;

    // Sequencer states; IDLE/HALT are the only states with no active stage.
    typedef enum logic [2:0] {
        S_IDLE,
        S_IF,
        S_ID,
        S_EX,
        S_MEM,
        S_WB,
        S_HALT
    } seq_state_t;

    // Bit positions of each stage in the one-hot stage vector.
    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    // Fetch address that ends execution.
    localparam logic [31:0] HALT_PC_DEFAULT = 32'h8008_8008;

endpackage

// File: rtl/multicycle_seq_if.sv
// Handshake/status bundle between the core side and the sequencer.
interface multicycle_seq_if #(
    parameter int CNT_W = 32
);
    logic             pc_rst;
    logic             jbr_taken;
    logic [31:0]      next_pc;
    logic             mem_access;
    logic             imem_ready;
    logic             dmem_ready;
    logic             stall;
    logic [4:0]       stage;
    logic             imem_req;
    logic             dmem_req;
    logic             halted;
    logic [CNT_W-1:0] retired_cnt;
    logic [CNT_W-1:0] cycle_cnt;

    // Core side: supplies status, consumes sequencing controls.
    modport master (
        output pc_rst, jbr_taken, next_pc, mem_access, imem_ready, dmem_ready,
        input  stall, stage, imem_req, dmem_req, halted, retired_cnt, cycle_cnt
    );

    // Sequencer side.
    modport slave (
        input  pc_rst, jbr_taken, next_pc, mem_access, imem_ready, dmem_ready,
        output stall, stage, imem_req, dmem_req, halted, retired_cnt, cycle_cnt
    );
endinterface

// File: rtl/multicycle_seq_perf_counter.sv
// Wrapping performance counter with enable and synchronous clear.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    // Clear has priority over counting; wraps modulo 2^CNT_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_seq.sv
// Multicycle sequencer: steps each instruction through IF/ID/EX/MEM/WB and
// lets the PC advance only in the WB (commit) cycle.
module multicycle_seq
    import proc_pkg::*;
#(
    parameter logic [31:0] HALT_PC = HALT_PC_DEFAULT,
    parameter int          CNT_W   = 32
) (
    input  logic           clk,
    input  logic           rst,
    multicycle_seq_if.slave bus
);

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic             active;
    logic             commit;
    logic [CNT_W-1:0] ret_cnt;
    logic [CNT_W-1:0] cyc_cnt;

    // State register; async reset drops straight to IDLE so stall rises at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; pc_rst overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (bus.pc_rst) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_IF;
                S_IF:   if (bus.imem_ready) state_d = S_ID;
                S_ID:   state_d = S_EX;
                S_EX:   state_d = bus.jbr_taken ? S_WB : S_MEM;
                S_MEM:  if (!bus.mem_access || bus.dmem_ready) state_d = S_WB;
                S_WB:   state_d = (bus.next_pc == HALT_PC) ? S_HALT : S_IF;
                S_HALT: state_d = S_HALT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs decoded from the registered state (dmem_req also gated by mem_access).
    always_comb begin
        bus.stage    = '0;
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.halted   = 1'b0;
        commit       = 1'b0;
        active       = 1'b1;
        unique case (state_q)
            S_IF: begin
                bus.stage[STG_IF] = 1'b1;
                bus.imem_req      = 1'b1;
            end
            S_ID:  bus.stage[STG_ID] = 1'b1;
            S_EX:  bus.stage[STG_EX] = 1'b1;
            S_MEM: begin
                bus.stage[STG_MEM] = 1'b1;
                bus.dmem_req       = bus.mem_access;
            end
            S_WB: begin
                bus.stage[STG_WB] = 1'b1;
                commit            = 1'b1;
            end
            S_HALT: begin
                bus.halted = 1'b1;
                active     = 1'b0;
            end
            default: active = 1'b0;
        endcase
        bus.stall = ~commit;
    end

    perf_counter #(.CNT_W(CNT_W)) u_retired (
        .clk (clk),
        .rst (rst),
        .clr (bus.pc_rst),
        .en  (commit),
        .cnt (ret_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_cycles (
        .clk (clk),
        .rst (rst),
        .clr (bus.pc_rst),
        .en  (active),
        .cnt (cyc_cnt)
    );

    assign bus.retired_cnt = ret_cnt;
    assign bus.cycle_cnt   = cyc_cnt;

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed bench for multicycle_seq: table of per-cycle vectors plus
// hand-written sequences for async reset and pc_rst/halt collision.
module tb_multicycle_seq;
    import proc_pkg::*;

    localparam int          CNT_W  = 32;
    localparam logic [31:0] OTHER_PC = 32'h0040_0010;

    logic clk;
    logic rst;

    multicycle_seq_if #(.CNT_W(CNT_W)) bus ();

    multicycle_seq #(.HALT_PC(HALT_PC_DEFAULT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        pr;
        logic        jb;
        logic        ma;
        logic        ir;
        logic        dr;
        logic        hp;
        logic        e_stall;
        logic [4:0]  e_stage;
        logic        e_imem;
        logic        e_dmem;
        logic        e_halt;
        logic        chk_cnt;
        int unsigned e_ret;
        int unsigned e_cyc;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic pr, jb, ma, ir, dr, hp,
                       input logic es, input logic [4:0] est, input logic ei, ed, eh,
                       input logic ck, input int unsigned er, ec);
        vec_t v;
        v = '{pr, jb, ma, ir, dr, hp, es, est, ei, ed, eh, ck, er, ec};
        vq.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pr, jb, ma, ir, dr, hp);
        bus.pc_rst     = pr;
        bus.jbr_taken  = jb;
        bus.mem_access = ma;
        bus.imem_ready = ir;
        bus.dmem_ready = dr;
        bus.next_pc    = hp ? HALT_PC_DEFAULT : OTHER_PC;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- table ----------------
        //  pr jb ma ir dr hp | stall stage imem dmem halt | chk ret cyc
        add(1,0,0,1,1,0, 1,5'h00,0,0,0, 1,0,0);   // IDLE held by pc_rst
        add(0,0,0,1,1,0, 1,5'h00,0,0,0, 1,0,0);   // IDLE, release
        for (int k = 0; k < 4; k++) begin         // four plain 5-cycle instructions
            add(0,0,0,1,1,0, 1,5'h01,1,0,0, 1,k,5*k);
            add(0,0,0,1,1,0, 1,5'h02,0,0,0, 0,0,0);
            add(0,0,0,1,1,0, 1,5'h04,0,0,0, 0,0,0);
            add(0,0,0,1,1,0, 1,5'h08,0,0,0, 0,0,0);
            add(0,0,0,1,1,0, 0,5'h10,0,0,0, 0,0,0);
        end
        // taken jump in EX; pulse in ID is ignored
        add(0,0,0,1,1,0, 1,5'h01,1,0,0, 1,4,20);
        add(0,1,0,1,1,0, 1,5'h02,0,0,0, 0,0,0);
        add(0,1,0,1,1,0, 1,5'h04,0,0,0, 0,0,0);
        add(0,1,0,1,1,0, 0,5'h10,0,0,0, 0,0,0);
        // jbr pulse in MEM only: full 5-cycle path
        add(0,0,0,1,1,0, 1,5'h01,1,0,0, 1,5,24);
        add(0,0,0,1,1,0, 1,5'h02,0,0,0, 0,0,0);
        add(0,0,0,1,1,0, 1,5'h04,0,0,0, 0,0,0);
        add(0,1,0,1,1,0, 1,5'h08,0,0,0, 0,0,0);
        add(0,0,0,1,1,0, 0,5'h10,0,0,0, 0,0,0);
        // imem 3 wait cycles, load with 2 dmem wait cycles: 10 cycles
        add(0,0,0,0,1,0, 1,5'h01,1,0,0, 1,6,29);
        add(0,0,0,0,1,0, 1,5'h01,1,0,0, 0,0,0);
        add(0,0,0,0,1,0, 1,5'h01,1,0,0, 0,0,0);
        add(0,0,0,1,1,0, 1,5'h01,1,0,0, 0,0,0);
        add(0,0,0,1,1,0, 1,5'h02,0,0,0, 0,0,0);
        add(0,0,0,1,1,0, 1,5'h04,0,0,0, 0,0,0);
        add(0,0,1,1,0,0, 1,5'h08,0,1,0, 0,0,0);
        add(0,0,1,1,0,0, 1,5'h08,0,1,0, 0,0,0);
        add(0,0,1,1,1,0, 1,5'h08,0,1,0, 0,0,0);
        add(0,0,0,1,1,0, 0,5'h10,0,0,0, 0,0,0);
        // halting instruction
        add(0,0,0,1,1,0, 1,5'h01,1,0,0, 1,7,39);
        add(0,0,0,1,1,0, 1,5'h02,0,0,0, 0,0,0);
        add(0,0,0,1,1,0, 1,5'h04,0,0,0, 0,0,0);
        add(0,0,0,1,1,0, 1,5'h08,0,0,0, 0,0,0);
        add(0,0,0,1,1,1, 0,5'h10,0,0,0, 0,0,0);
        add(0,0,0,1,1,0, 1,5'h00,0,0,1, 1,8,44);  // HALT
        add(0,1,1,1,1,1, 1,5'h00,0,0,1, 1,8,44);  // HALT ignores inputs, counters frozen
        add(1,0,0,1,1,0, 1,5'h00,0,0,1, 1,8,44);  // pc_rst pulse in HALT
        add(0,0,0,1,1,0, 1,5'h00,0,0,0, 1,0,0);   // back in IDLE, cleared

        // ---------------- reset ----------------
        rst = 1'b0;
        drive(1,0,0,1,1,0);
        #12;
        chk("rst_stall",  {31'd0, bus.stall},    32'd1);
        chk("rst_stage",  {27'd0, bus.stage},    32'd0);
        chk("rst_imem",   {31'd0, bus.imem_req}, 32'd0);
        chk("rst_halted", {31'd0, bus.halted},   32'd0);
        chk("rst_ret",    bus.retired_cnt,       32'd0);
        chk("rst_cyc",    bus.cycle_cnt,         32'd0);
        rst = 1'b1;
        step();

        // ---------------- table run ----------------
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].pr, vq[i].jb, vq[i].ma, vq[i].ir, vq[i].dr, vq[i].hp);
            #1;
            chk($sformatf("v%0d_stall", i),  {31'd0, bus.stall},    {31'd0, vq[i].e_stall});
            chk($sformatf("v%0d_stage", i),  {27'd0, bus.stage},    {27'd0, vq[i].e_stage});
            chk($sformatf("v%0d_imem", i),   {31'd0, bus.imem_req}, {31'd0, vq[i].e_imem});
            chk($sformatf("v%0d_dmem", i),   {31'd0, bus.dmem_req}, {31'd0, vq[i].e_dmem});
            chk($sformatf("v%0d_halted", i), {31'd0, bus.halted},   {31'd0, vq[i].e_halt});
            if (vq[i].chk_cnt) begin
                chk($sformatf("v%0d_ret", i), bus.retired_cnt, vq[i].e_ret);
                chk($sformatf("v%0d_cyc", i), bus.cycle_cnt,   vq[i].e_cyc);
            end
            step();
        end

        // ---------------- async reset mid-MEM ----------------
        // state is IF here
        drive(0,0,0,1,1,0);
        step();                       // ID
        step();                       // EX
        step();                       // MEM
        drive(0,0,1,1,0,0);
        #1;
        chk("mem_stage", {27'd0, bus.stage},    32'h08);
        chk("mem_dmem",  {31'd0, bus.dmem_req}, 32'd1);
        chk("mem_cyc",   bus.cycle_cnt,         32'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_stall", {31'd0, bus.stall},    32'd1);
        chk("arst_stage", {27'd0, bus.stage},    32'd0);
        chk("arst_dmem",  {31'd0, bus.dmem_req}, 32'd0);
        chk("arst_cyc",   bus.cycle_cnt,         32'd0);
        drive(1,0,0,1,1,0);
        #1;
        rst = 1'b1;

        // ---------------- pc_rst with WB halt match ----------------
        step();                       // IDLE
        drive(0,0,0,1,1,0);
        step();                       // IF
        step();                       // ID
        step();                       // EX
        drive(0,1,0,1,1,0);
        step();                       // WB
        drive(1,0,0,1,1,1);
        #1;
        chk("col_wb_stall", {31'd0, bus.stall}, 32'd0);
        chk("col_wb_stage", {27'd0, bus.stage}, 32'h10);
        step();                       // IDLE, not HALT
        chk("col_halted", {31'd0, bus.halted}, 32'd0);
        chk("col_stage",  {27'd0, bus.stage},  32'd0);
        chk("col_stall",  {31'd0, bus.stall},  32'd1);
        chk("col_ret",    bus.retired_cnt,     32'd0);
        chk("col_cyc",    bus.cycle_cnt,       32'd0);
        step();
        chk("col_halted2", {31'd0, bus.halted}, 32'd0);
        drive(0,0,0,1,1,0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
